fetch_unit: RTL and testbench

//  Instruction-fetch and PC-sequencing stage; sits directly upstream of the main control decoder.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_next_pc_calc.sv | 32 +++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcodes, FSM state encoding, instruction field positions
// and the branch-offset helper.
package fetch_unit_pkg;

  localparam logic [7:0] OpcHalt    = 8'h00;
  localparam logic [7:0] OpcRformat = 8'h01;
  localparam logic [7:0] OpcLw      = 8'h02;
  localparam logic [7:0] OpcSw      = 8'h03;
  localparam logic [7:0] OpcJ       = 8'h04;
  localparam logic [7:0] OpcBeq     = 8'h05;
  localparam logic [7:0] OpcBne     = 8'h06;
  localparam logic [7:0] OpcAddi    = 8'h07;

  localparam int unsigned OpcMsb    = 31;
  localparam int unsigned OpcLsb    = 24;
  localparam int unsigned TargetMsb = 23;
  localparam int unsigned ImmMsb    = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output addr, input rdata, input ack);
  modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump > beq > bne > sequential, all sums wrapping mod 2^32.
module fetch_unit_next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic        unused_opc;

  assign pc4        = pc + 32'd4;
  assign unused_opc = ^instr[OpcMsb:OpcLsb];

  // beq shadows bne entirely when both are asserted.
  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:26], instr[TargetMsb:0], 2'b00};
    end else if (beq) begin
      if (zero) next_pc = pc4 + branch_offset(instr[ImmMsb:0]);
    end else if (bne) begin
      if (!zero) next_pc = pc4 + branch_offset(instr[ImmMsb:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: fetches over a req/ack bus, presents each instruction for
// one execute cycle (longer when stalled), advances the PC and counts retirements until HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  HALT_OPC = OpcHalt
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         pc,
  input  logic                jump,
  input  logic                beq,
  input  logic                bne,
  input  logic                zero,
  input  logic                stall,
  output logic                halted,
  output logic [31:0]         retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, instr_q, retired_q;
  logic [31:0] next_pc;
  logic        fetch_done, commit;

  // Acks outside FETCH are dropped here, which also covers a late ack after reset.
  assign fetch_done = (state_q == StFetch) && imem.ack;
  assign commit     = (state_q == StExec) && !stall;

  fetch_unit_next_pc_calc u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q),
    .jump    (jump),
    .beq     (beq),
    .bne     (bne),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (imem.ack) begin
          state_d = (imem.rdata[OpcMsb:OpcLsb] == HALT_OPC) ? StHalt : StExec;
        end
      end
      StExec:  if (!stall) state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem.req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      StFetch: imem.req    = 1'b1;
      StExec:  instr_valid = 1'b1;
      StHalt:  halted      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      if (fetch_done) instr_q <= imem.rdata;
      if (commit) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign imem.addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequencing, branches, jumps, fetch latency, stall, halt
// and reset during an outstanding fetch.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0, beq = 1'b0, bne = 1'b0, zero = 1'b0, stall = 1'b0;
  logic [31:0] instr, pc, retired;
  logic        instr_valid, halted;
  logic [31:0] exp_ret = 32'd0;
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .jump        (jump),
    .beq         (beq),
    .bne         (bne),
    .zero        (zero),
    .stall       (stall),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a request, acks on the lat-th request cycle; returns just after the edge.
  task automatic fetch_word(input logic [31:0] word, input int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (imem_bus.req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (imem_bus.req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", imem_bus.req);
    end
    repeat (lat - 1) @(negedge clk);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = word;
    @(posedge clk);
    #1;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'hDEAD_BEEF;
  endtask

  task automatic exec_cycle(input logic j, input logic b, input logic n, input logic z);
    jump = j; beq = b; bne = n; zero = z;
    @(posedge clk);
    #1;
    jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] word, input logic [3:0] f);
    fetch_word(word, 1);
    exec_cycle(f[3], f[2], f[1], f[0]);
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 32'd0;
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || retired !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h instr=%h retired=%h required 0/0/0", pc, instr, retired);
    end
    checks++;
    if ({imem_bus.req, instr_valid, halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs: req/valid/halted=%b required 000",
               {imem_bus.req, instr_valid, halted});
    end
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1/0", imem_bus.req, imem_bus.addr);
    end
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h0100_0000;
    @(posedge clk);
    #1 imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0100_0000 || pc !== 32'h0 || imem_bus.req !== 1'b0)
    begin
      errors++;
      $display("FAIL first_exec: valid=%b instr=%h pc=%h req=%b required 1/01000000/0/0",
               instr_valid, instr, pc, imem_bus.req);
    end
    exec_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    exp_ret = exp_ret + 32'd1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 32'h4 || retired !== 32'd1) begin
      errors++;
      $display("FAIL first_retire: valid=%b pc=%h retired=%0d required 0/4/1",
               instr_valid, pc, retired);
    end
  endtask

  task automatic test_branch();
    logic [31:0] w [6];
    logic [3:0]  f [6];
    logic [31:0] e [6];
    w = '{32'h0400_0004, 32'h0500_FFFE, 32'h0400_0004, 32'h0500_FFFE, 32'h0600_0003,
          32'h0600_0003};
    f = '{4'b1000, 4'b0101, 4'b1000, 4'b0100, 4'b0010, 4'b0011};
    e = '{32'h10, 32'h0C, 32'h10, 32'h14, 32'h24, 32'h28};
    for (int i = 0; i < 6; i++) begin
      run_instr(w[i], f[i]);
      @(negedge clk);
      checks++;
      if (pc !== e[i]) begin
        errors++;
        $display("FAIL branch_%0d: pc=%h required %h", i, pc, e[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] w [10];
    logic [3:0]  f [10];
    logic [31:0] e [10];
    w = '{32'h04FF_FFFF, 32'h0200_0000, 32'h04FF_FFFF, 32'h0200_0000, 32'h04FF_FFFF,
          32'h0200_0000, 32'h04FF_FFFF, 32'h0200_0000, 32'h0400_0040, 32'h0500_0080};
    f = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000,
          4'b1101};
    e = '{32'h03FF_FFFC, 32'h0400_0000, 32'h07FF_FFFC, 32'h0800_0000, 32'h0BFF_FFFC,
          32'h0C00_0000, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0100, 32'h1000_0200};
    for (int i = 0; i < 10; i++) begin
      run_instr(w[i], f[i]);
      @(negedge clk);
      checks++;
      if (pc !== e[i]) begin
        errors++;
        $display("FAIL jump_%0d: pc=%h required %h", i, pc, e[i]);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL jump_retired: retired=%0d required %0d", retired, exp_ret);
    end
  endtask

  task automatic test_delay_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h1000_0200) begin
        errors++;
        $display("FAIL delay_req_%0d: req=%b addr=%h required 1/10000200",
                 i, imem_bus.req, imem_bus.addr);
      end
      if (i == 4) begin
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h0712_3456;
      end
    end
    @(posedge clk);
    #1 imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (imem_bus.req !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL delay_end: req=%b valid=%b required 0/1", imem_bus.req, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h0399_9999;
      end
      @(posedge clk);
      #1 imem_bus.ack = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h1000_0200 || instr !== 32'h0712_3456 ||
          retired !== exp_ret) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b pc=%h instr=%h retired=%0d required 1/10000200/07123456/%0d",
                 i, instr_valid, pc, instr, retired, exp_ret);
      end
    end
    stall = 1'b0;
    @(posedge clk);
    #1 exp_ret = exp_ret + 32'd1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 32'h1000_0204 || retired !== exp_ret) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h retired=%0d required 0/10000204/%0d",
               instr_valid, pc, retired, exp_ret);
    end
  endtask

  task automatic test_halt();
    fetch_word(32'h00AB_CDEF, 1);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h00AB_CDEF) begin
      errors++;
      $display("FAIL halt_enter: halted=%b valid=%b instr=%h required 1/0/00abcdef",
               halted, instr_valid, instr);
    end
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h0100_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (imem_bus.req !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold_%0d: req=%b halted=%b required 0/1", i, imem_bus.req, halted);
      end
    end
    imem_bus.ack = 1'b0;
    checks++;
    if (retired !== exp_ret || pc !== 32'h1000_0204) begin
      errors++;
      $display("FAIL halt_count: retired=%0d pc=%h required %0d/10000204", retired, pc, exp_ret);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 32'd0;
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || halted !== 1'b0 || retired !== 32'h0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b retired=%0d instr=%h required 0/0/0/0",
               pc, halted, retired, instr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    checks++;
    if (imem_bus.req !== 1'b1) begin
      errors++;
      $display("FAIL midrst_req: req=%b required 1", imem_bus.req);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h0155_5555;
    @(negedge clk);
    checks++;
    if (imem_bus.req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: req=%b required 0", imem_bus.req);
    end
    @(posedge clk);
    #1 imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (instr !== 32'h0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0 ||
        instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_refetch: instr=%h req=%b addr=%h valid=%b required 0/1/0/0",
               instr, imem_bus.req, imem_bus.addr, instr_valid);
    end
    run_instr(32'h0500_FFFE, 4'b0101);
    @(negedge clk);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_branch: pc=%h required fffffffc", pc);
    end
    run_instr(32'h0100_0000, 4'b0000);
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || retired !== 32'd2) begin
      errors++;
      $display("FAIL wrap_seq: pc=%h retired=%0d required 0/2", pc, retired);
    end
  endtask

  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_delay_stall();
    test_halt();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
